// File: rtl/control_multi_fsm.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory wait states, sticky HALT and illegal trap; CTRL_JUMP_EN enables J.
// Latency: R L+3, LW 2L+3, SW 2L+2, BEQ/J L+2 cycles (L = MEM_LAT); outputs are Moore, registered state only.
// Backpressure: none; memory latency is fixed by MEM_LAT, HALTED/ILLEGAL hold until reset.
module control_multi_fsm #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Halt,
    output logic       Illegal,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXEC    = 4'd6,
        ST_RCOMP   = 4'd7,
        ST_BRANCH  = 4'd8,
`ifdef CTRL_JUMP_EN
        ST_JUMP    = 4'd9,
`endif
        ST_HALTED  = 4'd10,
        ST_ILLEGAL = 4'd11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last;

    // Final cycle of a held memory state; with MEM_LAT==1 every cycle is final.
    assign last = (cnt_q == CNT_W'(MEM_LAT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_FETCH: begin
                if (last) state_d = ST_DECODE;
                else      cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_DECODE: begin
                case (opcode)
                    6'd0:        state_d = ST_EXEC;
                    6'd35, 6'd43: state_d = ST_MEMADR;
                    6'd4:        state_d = ST_BRANCH;
`ifdef CTRL_JUMP_EN
                    6'd2:        state_d = ST_JUMP;
`endif
                    6'd63:       state_d = ST_HALTED;
                    default:     state_d = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR: state_d = (opcode == 6'd35) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                if (last) state_d = ST_MEMWB;
                else      cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_MEMWB:  state_d = ST_FETCH;
            ST_MEMWR: begin
                if (last) state_d = ST_FETCH;
                else      cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_EXEC:   state_d = ST_RCOMP;
            ST_RCOMP:  state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
`ifdef CTRL_JUMP_EN
            ST_JUMP:   state_d = ST_FETCH;
`endif
            ST_HALTED:  state_d = ST_HALTED;
            ST_ILLEGAL: state_d = ST_ILLEGAL;
            default:    state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        Halt        = 1'b0;
        Illegal     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = last;
                PCWrite = last;
            end
            ST_DECODE: ALUSrcB = 2'b11;
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            ST_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            ST_RCOMP: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
`ifdef CTRL_JUMP_EN
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
`endif
            ST_HALTED:  Halt    = 1'b1;
            ST_ILLEGAL: Illegal = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_control_multi_fsm.sv
// Bench for control_multi_fsm: three instances (MEM_LAT 1,2,3), per-cycle expected control words
// queued from the instruction timing table and popped against the DUT outputs.
module tb_control_multi_fsm;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                   S_MEMWR = 5, S_EXEC = 6, S_RCOMP = 7, S_BRANCH = 8, S_JUMP = 9,
                   S_HALTED = 10, S_ILLEGAL = 11;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       irwrite;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       halt;
        logic       illegal;
        logic [3:0] state;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset [3];
    logic [5:0] opc   [3];
    ctl_t       obs   [3];
    ctl_t       exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rwr, asa, hlt, ill;
        logic [1:0] asb, aop, psrc;
        logic [3:0] st;
        control_multi_fsm #(.MEM_LAT(g + 1), .CNT_W(4)) u_dut (
            .clk(clk), .reset(reset[g]), .opcode(opc[g]),
            .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mrd),
            .MemWrite(mwr), .MemtoReg(m2r), .IRWrite(irw), .RegDst(rdst),
            .RegWrite(rwr), .ALUSrcA(asa), .ALUSrcB(asb), .ALUOp(aop),
            .PCSource(psrc), .Halt(hlt), .Illegal(ill), .state_o(st)
        );
        assign obs[g] = {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rwr, asa,
                         asb, aop, psrc, hlt, ill, st};
    end

    task automatic check_vec(input string tag, input ctl_t got, input ctl_t want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic ctl_t exp_vec(input int st, input bit last);
        ctl_t v;
        v       = '0;
        v.state = st[3:0];
        case (st)
            S_FETCH:   begin v.memread = 1; v.alusrcb = 2'b01; v.irwrite = last; v.pcwrite = last; end
            S_DECODE:  v.alusrcb = 2'b11;
            S_MEMADR:  begin v.alusrca = 1; v.alusrcb = 2'b10; end
            S_MEMRD:   begin v.memread = 1; v.iord = 1; end
            S_MEMWB:   begin v.regwrite = 1; v.memtoreg = 1; end
            S_MEMWR:   begin v.memwrite = 1; v.iord = 1; end
            S_EXEC:    begin v.alusrca = 1; v.aluop = 2'b10; end
            S_RCOMP:   begin v.regdst = 1; v.regwrite = 1; end
            S_BRANCH:  begin v.alusrca = 1; v.aluop = 2'b01; v.pcwritecond = 1; v.pcsource = 2'b01; end
            S_JUMP:    begin v.pcwrite = 1; v.pcsource = 2'b10; end
            S_HALTED:  v.halt = 1;
            S_ILLEGAL: v.illegal = 1;
            default: ;
        endcase
        return v;
    endfunction

    task automatic push_st(input int st, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_vec(st, i == n - 1));
    endtask

    task automatic consume(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            ctl_t e;
            e = exp_q.pop_front();
            check_vec($sformatf("L%0d st%0d", d + 1, e.state), obs[d], e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int d);
        reset[d] = 1'b1;
        @(posedge clk);
        #1;
        check_vec($sformatf("L%0d reset", d + 1), obs[d], exp_vec(S_FETCH, d == 0));
        reset[d] = 1'b0;
    endtask

    // Queue the full per-cycle trace of one instruction; sticky ends get `tail` cycles.
    task automatic build(input int d, input logic [5:0] op, input int tail);
        int l;
        l      = d + 1;
        opc[d] = op;
        push_st(S_FETCH, l);
        push_st(S_DECODE, 1);
        case (op)
            6'd0:  begin push_st(S_EXEC, 1); push_st(S_RCOMP, 1); end
            6'd35: begin push_st(S_MEMADR, 1); push_st(S_MEMRD, l); push_st(S_MEMWB, 1); end
            6'd43: begin push_st(S_MEMADR, 1); push_st(S_MEMWR, l); end
            6'd4:  push_st(S_BRANCH, 1);
`ifdef CTRL_JUMP_EN
            6'd2:  push_st(S_JUMP, 1);
`endif
            6'd63: push_st(S_HALTED, tail);
            default: push_st(S_ILLEGAL, tail);
        endcase
    endtask

    task automatic run(input int d, input logic [5:0] op, input int tail);
        build(d, op, tail);
        consume(d, exp_q.size());
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            reset[i] = 1'b1;
            opc[i]   = 6'd0;
        end
        repeat (2) @(posedge clk);
        #1;

        // MEM_LAT = 1: classic timing, every instruction class back-to-back.
        do_reset(0);
        run(0, 6'd0, 0);
        run(0, 6'd4, 0);
        run(0, 6'd35, 0);
        run(0, 6'd43, 0);
        run(0, 6'd2, 5);
        do_reset(0);
        run(0, 6'd63, 20);
        do_reset(0);
        run(0, 6'd0, 0);

        // MEM_LAT = 2: stores/loads with wait states, unknown opcode traps.
        do_reset(1);
        run(1, 6'd43, 0);
        run(1, 6'd35, 0);
        run(1, 6'd13, 4);
        do_reset(1);
        run(1, 6'd4, 0);

        // MEM_LAT = 3: load, then a load aborted by reset inside MEMRD.
        do_reset(2);
        run(2, 6'd35, 0);
        run(2, 6'd0, 0);
        build(2, 6'd35, 0);
        consume(2, 6);
        exp_q.delete();
        do_reset(2);
        run(2, 6'd4, 0);
        run(2, 6'd2, 3);
        do_reset(2);
        run(2, 6'd43, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
